// File: rtl/sample_queue_pkg.sv
// Shared types and helpers for the per-channel sample window queue.
package sample_queue_pkg;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    ARMED   = 2'd1,
    READOUT = 2'd2
  } sq_state_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dp_ram_sync.sv
// Simple dual-port RAM: one write port, one registered read-before-write read port.
module dp_ram_sync
  import sample_queue_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  localparam int AW = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             re,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rd_data_r;

  // storage array write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // output register holds its value between reads and clears on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= {WIDTH{1'b0}};
    end else if (re) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/sample_window_queue.sv
// Circular sample queue keeping the newest WINDOW samples; every accepted sample
// once full triggers an oldest-first burst readout with first/last framing.
module sample_window_queue
  import sample_queue_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 1024,
  parameter int WINDOW = 1021
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrt_smpl,
  input  logic [WIDTH-1:0] new_smpl,
  input  logic             flush,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] smpl_out,
  output logic             smpl_vld,
  output logic             smpl_first,
  output logic             smpl_last,
  output logic             sequencing,
  output logic             full,
  output logic             ovr
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(WINDOW + 1);
  localparam logic [PW-1:0] WIN_P  = PW'(WINDOW);
  localparam logic [PW-1:0] LAST_P = PW'(WINDOW - 1);
  localparam logic [CW-1:0] FULL_P = CW'(WINDOW);
  localparam logic [PW:0]   OVR_P  = (PW + 1)'(DEPTH - WINDOW);

  sq_state_t     state_r, state_nxt_s;
  logic [PW-1:0] wr_ptr_r, wr_ptr_nxt_s, rd_ptr_r, rd_cnt_r, base_s;
  logic [CW-1:0] fill_cnt_r, fill_cnt_nxt_s;
  logic [PW:0]   wcnt_r;
  logic          pending_r, pending_nxt_s, start_s;
  logic          we_s, rd_en_s, last_rd_s, ovr_evt_s;
  logic          smpl_vld_r, smpl_first_r, smpl_last_r, sequencing_r, full_r, ovr_r;

  // write/read qualifiers and the window base seen after this cycle's write
  always_comb begin
    we_s         = wrt_smpl & ~flush;
    wr_ptr_nxt_s = we_s ? (wr_ptr_r + PW'(1'b1)) : wr_ptr_r;
    base_s       = wr_ptr_nxt_s - WIN_P;
    rd_en_s      = (state_r == READOUT) & ~flush;
    last_rd_s    = rd_en_s & (rd_cnt_r == LAST_P);
    ovr_evt_s    = we_s & (state_r == READOUT) & (wcnt_r >= OVR_P);
    if (flush) begin
      fill_cnt_nxt_s = {CW{1'b0}};
    end else if (we_s && (fill_cnt_r != FULL_P)) begin
      fill_cnt_nxt_s = fill_cnt_r + CW'(1'b1);
    end else begin
      fill_cnt_nxt_s = fill_cnt_r;
    end
  end

  // next-state logic; start_s marks the edge that loads a new burst base
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    if (flush) begin
      state_nxt_s = FILL;
    end else begin
      case (state_r)
        FILL: begin
          if (we_s && (fill_cnt_r == (FULL_P - CW'(1'b1)))) begin
            state_nxt_s = READOUT;
            start_s     = 1'b1;
          end else begin
            state_nxt_s = FILL;
          end
        end
        ARMED: begin
          if (we_s) begin
            state_nxt_s = READOUT;
            start_s     = 1'b1;
          end else begin
            state_nxt_s = ARMED;
          end
        end
        READOUT: begin
          if (last_rd_s && (pending_r || we_s)) begin
            state_nxt_s = READOUT;
            start_s     = 1'b1;
          end else if (last_rd_s) begin
            state_nxt_s = ARMED;
          end else begin
            state_nxt_s = READOUT;
          end
        end
        default: begin
          state_nxt_s = FILL;
        end
      endcase
    end
  end

  // a write that lands while a burst runs requests a follow-up burst
  always_comb begin
    if (flush || start_s) begin
      pending_nxt_s = 1'b0;
    end else if (we_s && (state_r == READOUT)) begin
      pending_nxt_s = 1'b1;
    end else begin
      pending_nxt_s = pending_r;
    end
  end

  // control state, pointers and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= FILL;
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      rd_cnt_r   <= {PW{1'b0}};
      fill_cnt_r <= {CW{1'b0}};
      pending_r  <= 1'b0;
      wcnt_r     <= {(PW + 1){1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      wr_ptr_r   <= wr_ptr_nxt_s;
      fill_cnt_r <= fill_cnt_nxt_s;
      pending_r  <= pending_nxt_s;
      if (start_s) begin
        rd_ptr_r <= base_s;
        rd_cnt_r <= {PW{1'b0}};
      end else if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
        rd_cnt_r <= rd_cnt_r + PW'(1'b1);
      end
      // writes are tallied across one uninterrupted readout period
      if ((state_r != READOUT) || flush) begin
        wcnt_r <= {(PW + 1){1'b0}};
      end else if (we_s && (wcnt_r <= OVR_P)) begin
        wcnt_r <= wcnt_r + (PW + 1)'(1'b1);
      end
    end
  end

  // registered framing and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      smpl_vld_r   <= 1'b0;
      smpl_first_r <= 1'b0;
      smpl_last_r  <= 1'b0;
      sequencing_r <= 1'b0;
      full_r       <= 1'b0;
      ovr_r        <= 1'b0;
    end else begin
      smpl_vld_r   <= rd_en_s;
      smpl_first_r <= rd_en_s & (rd_cnt_r == {PW{1'b0}});
      smpl_last_r  <= last_rd_s;
      sequencing_r <= (state_nxt_s == READOUT) | rd_en_s;
      full_r       <= (fill_cnt_nxt_s == FULL_P);
      ovr_r        <= ovr_evt_s | (ovr_r & ~clr_ovr);
    end
  end

  dp_ram_sync #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (we_s),
    .wr_addr (wr_ptr_r),
    .wr_data (new_smpl),
    .re      (rd_en_s),
    .rd_addr (rd_ptr_r),
    .rd_data (smpl_out)
  );

  assign smpl_vld   = smpl_vld_r;
  assign smpl_first = smpl_first_r;
  assign smpl_last  = smpl_last_r;
  assign sequencing = sequencing_r;
  assign full       = full_r;
  assign ovr        = ovr_r;

endmodule

// File: tb/tb_sample_window_queue.sv
// Scoreboard bench: a 16/16/8 instance for timing/overrun/flush, a default instance for the long window.
module tb_sample_window_queue;

  typedef struct packed {
    logic [15:0] d;
    logic        first;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_rst, s_wr, s_flush, s_clr;
  logic [15:0] s_d, s_out;
  logic        s_vld, s_first, s_last, s_seq, s_full, s_ovr;
  logic        b_rst, b_wr, b_flush, b_clr;
  logic [15:0] b_d, b_out;
  logic        b_vld, b_first, b_last, b_seq, b_full, b_ovr;

  exp_t        sq[$];
  exp_t        bq[$];
  logic [15:0] s_hist[$];
  logic [15:0] b_hist[$];
  exp_t        s_e, b_e;
  int          n_checks = 0;
  int          n_pass = 0;

  sample_window_queue #(.WIDTH(16), .DEPTH(16), .WINDOW(8)) u_small (
    .clk(clk), .rst(s_rst), .wrt_smpl(s_wr), .new_smpl(s_d), .flush(s_flush), .clr_ovr(s_clr),
    .smpl_out(s_out), .smpl_vld(s_vld), .smpl_first(s_first), .smpl_last(s_last),
    .sequencing(s_seq), .full(s_full), .ovr(s_ovr)
  );

  sample_window_queue u_big (
    .clk(clk), .rst(b_rst), .wrt_smpl(b_wr), .new_smpl(b_d), .flush(b_flush), .clr_ovr(b_clr),
    .smpl_out(b_out), .smpl_vld(b_vld), .smpl_first(b_first), .smpl_last(b_last),
    .sequencing(b_seq), .full(b_full), .ovr(b_ovr)
  );

  // scoreboard pop/compare for each valid output beat, sampled on the falling edge
  always @(negedge clk) begin
    if (s_vld === 1'b1) begin
      n_checks++;
      if (sq.size() == 0) begin
        $display("FAIL s_data: got unexpected sample %0h, required no output", s_out);
      end else begin
        s_e = sq.pop_front();
        if ({s_out, s_first, s_last} !== {s_e.d, s_e.first, s_e.last})
          $display("FAIL s_data: got %0h f%0b l%0b, required %0h f%0b l%0b",
                   s_out, s_first, s_last, s_e.d, s_e.first, s_e.last);
        else n_pass++;
      end
    end
    if (b_vld === 1'b1) begin
      n_checks++;
      if (bq.size() == 0) begin
        $display("FAIL b_data: got unexpected sample %0h, required no output", b_out);
      end else begin
        b_e = bq.pop_front();
        if ({b_out, b_first, b_last} !== {b_e.d, b_e.first, b_e.last})
          $display("FAIL b_data: got %0h f%0b l%0b, required %0h f%0b l%0b",
                   b_out, b_first, b_last, b_e.d, b_e.first, b_e.last);
        else n_pass++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_win_s();
    exp_t e;
    int n = s_hist.size();
    for (int i = n - 8; i < n; i++) begin
      e.d = s_hist[i]; e.first = (i == n - 8); e.last = (i == n - 1);
      sq.push_back(e);
    end
  endtask

  task automatic push_win_b();
    exp_t e;
    int n = b_hist.size();
    for (int i = n - 1021; i < n; i++) begin
      e.d = b_hist[i]; e.first = (i == n - 1021); e.last = (i == n - 1);
      bq.push_back(e);
    end
  endtask

  task automatic s_write(input logic [15:0] v, input bit trig);
    s_wr = 1'b1; s_d = v;
    s_hist.push_back(v);
    if (trig) push_win_s();
    cyc();
    s_wr = 1'b0;
  endtask

  task automatic b_write(input logic [15:0] v, input bit trig);
    b_wr = 1'b1; b_d = v;
    b_hist.push_back(v);
    if (trig) push_win_b();
    cyc();
    b_wr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) cyc();
    n_checks++;
    if ({s_out, s_vld, s_first, s_last, s_seq, s_full, s_ovr} !== 22'd0)
      $display("FAIL reset_small: got %0h required 0", {s_out, s_vld, s_first, s_last, s_seq, s_full, s_ovr});
    else n_pass++;
    n_checks++;
    if ({b_out, b_vld, b_first, b_last, b_seq, b_full, b_ovr} !== 22'd0)
      $display("FAIL reset_big: got %0h required 0", {b_out, b_vld, b_first, b_last, b_seq, b_full, b_ovr});
    else n_pass++;
    s_rst = 1'b0; b_rst = 1'b0;
    cyc();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) begin
        n_checks++;
        if (s_full !== 1'b0) $display("FAIL fill_not_full: got %0b required 0", s_full); else n_pass++;
      end
      s_write(16'(i), i == 8);
      if (i < 8) repeat (19) cyc();
    end
    n_checks++;
    if ({s_seq, s_vld} !== 2'b10) $display("FAIL fill_t1: got seq/vld %b required 10", {s_seq, s_vld}); else n_pass++;
    cyc();
    n_checks++;
    if ({s_vld, s_first, s_last} !== 3'b110) $display("FAIL fill_first: got %b required 110", {s_vld, s_first, s_last}); else n_pass++;
    repeat (6) cyc();
    n_checks++;
    if ({s_vld, s_first, s_last} !== 3'b100) $display("FAIL fill_mid: got %b required 100", {s_vld, s_first, s_last}); else n_pass++;
    cyc();
    n_checks++;
    if ({s_vld, s_first, s_last, s_seq} !== 4'b1011) $display("FAIL fill_last: got %b required 1011", {s_vld, s_first, s_last, s_seq}); else n_pass++;
    cyc();
    n_checks++;
    if ({s_vld, s_seq, s_full} !== 3'b001) $display("FAIL fill_end: got vld/seq/full %b required 001", {s_vld, s_seq, s_full}); else n_pass++;
  endtask

  task automatic test_stream();
    for (int v = 9; v <= 20; v++) begin
      s_write(16'(v), 1'b1);
      repeat (11) cyc();
    end
    n_checks++;
    if (sq.size() != 0) $display("FAIL stream_drain: got %0d pending beats required 0", sq.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int gaps = 0;
    s_write(16'd21, 1'b1);
    repeat (2) cyc();
    s_write(16'd22, 1'b1);
    for (int j = 4; j <= 17; j++) begin
      if (s_seq !== 1'b1) gaps++;
      if (j == 9) begin
        n_checks++;
        if ({s_vld, s_first, s_last} !== 3'b101) $display("FAIL chain_last: got %b required 101", {s_vld, s_first, s_last}); else n_pass++;
      end
      if (j == 10) begin
        n_checks++;
        if ({s_vld, s_first, s_last} !== 3'b110) $display("FAIL chain_first: got %b required 110", {s_vld, s_first, s_last}); else n_pass++;
      end
      if (j < 17) cyc();
    end
    n_checks++;
    if (gaps != 0) $display("FAIL chain_seq_gap: got %0d low cycles required 0", gaps); else n_pass++;
    cyc();
    n_checks++;
    if ({s_seq, s_ovr} !== 2'b00) $display("FAIL chain_end: got seq/ovr %b required 00", {s_seq, s_ovr}); else n_pass++;
  endtask

  task automatic test_overrun();
    int t = 0;
    s_write(16'd23, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      s_write(16'(23 + k), k >= 8);
      if (k == 8) begin
        n_checks++;
        if (s_ovr !== 1'b0) $display("FAIL ovr_early: got %0b required 0", s_ovr); else n_pass++;
      end
    end
    n_checks++;
    if (s_ovr !== 1'b1) $display("FAIL ovr_set: got %0b required 1", s_ovr); else n_pass++;
    while (s_seq === 1'b1 && t < 60) begin cyc(); t++; end
    n_checks++;
    if (s_seq !== 1'b0) $display("FAIL ovr_drain_timeout: got seq %0b required 0", s_seq); else n_pass++;
    n_checks++;
    if (sq.size() != 0) $display("FAIL ovr_beats: got %0d pending beats required 0", sq.size()); else n_pass++;
    s_clr = 1'b1;
    cyc();
    s_clr = 1'b0;
    n_checks++;
    if (s_ovr !== 1'b0) $display("FAIL ovr_clear: got %0b required 0", s_ovr); else n_pass++;
  endtask

  task automatic test_flush();
    int t = 0;
    s_write(16'd33, 1'b1);
    repeat (4) cyc();
    s_flush = 1'b1; s_wr = 1'b1; s_d = 16'h0999;
    cyc();
    s_flush = 1'b0; s_wr = 1'b0;
    sq.delete();
    s_hist.delete();
    n_checks++;
    if ({s_vld, s_seq, s_full} !== 3'b000) $display("FAIL flush_stop: got vld/seq/full %b required 000", {s_vld, s_seq, s_full}); else n_pass++;
    for (int v = 41; v <= 48; v++) begin
      s_write(16'(v), v == 48);
      if (v == 47) begin
        n_checks++;
        if ({s_seq, s_full} !== 2'b00) $display("FAIL flush_refill: got seq/full %b required 00", {s_seq, s_full}); else n_pass++;
      end
    end
    n_checks++;
    if ({s_seq, s_full} !== 2'b11) $display("FAIL flush_retrigger: got seq/full %b required 11", {s_seq, s_full}); else n_pass++;
    while (s_seq === 1'b1 && t < 40) begin cyc(); t++; end
    n_checks++;
    if (sq.size() != 0 || s_seq !== 1'b0) $display("FAIL flush_burst: got %0d pending beats seq %0b required 0 0", sq.size(), s_seq); else n_pass++;
  endtask

  task automatic test_default_window();
    int vld_cnt = 0;
    for (int i = 1; i <= 1021; i++) b_write(16'(i), i == 1021);
    n_checks++;
    if ({b_seq, b_full} !== 2'b11) $display("FAIL big_start: got seq/full %b required 11", {b_seq, b_full}); else n_pass++;
    for (int j = 2; j <= 1022; j++) begin
      cyc();
      if (b_vld === 1'b1) vld_cnt++;
    end
    n_checks++;
    if (vld_cnt != 1021) $display("FAIL big_contiguous: got %0d valid cycles required 1021", vld_cnt); else n_pass++;
    cyc();
    n_checks++;
    if ({b_vld, b_seq, bq.size() == 0} !== 3'b001) $display("FAIL big_end: got vld/seq/empty %b required 001", {b_vld, b_seq, bq.size() == 0}); else n_pass++;
  endtask

  task automatic test_rst_midburst();
    b_write(16'd1022, 1'b1);
    repeat (50) cyc();
    b_rst = 1'b1;
    cyc();
    b_rst = 1'b0;
    bq.delete();
    b_hist.delete();
    n_checks++;
    if ({b_out, b_vld, b_first, b_last, b_seq, b_full, b_ovr} !== 22'd0)
      $display("FAIL big_rst: got %0h required 0", {b_out, b_vld, b_first, b_last, b_seq, b_full, b_ovr});
    else n_pass++;
    b_write(16'h0005, 1'b0);
    cyc();
    n_checks++;
    if ({b_vld, b_seq, b_full} !== 3'b000) $display("FAIL big_rst_fill: got vld/seq/full %b required 000", {b_vld, b_seq, b_full}); else n_pass++;
  endtask

  initial begin
    s_rst = 1'b1; s_wr = 1'b0; s_d = 16'h0; s_flush = 1'b0; s_clr = 1'b0;
    b_rst = 1'b1; b_wr = 1'b0; b_d = 16'h0; b_flush = 1'b0; b_clr = 1'b0;
    test_reset();
    test_fill();
    test_stream();
    test_back_to_back();
    test_overrun();
    test_flush();
    test_default_window();
    test_rst_midburst();
    n_checks++;
    if (sq.size() != 0 || bq.size() != 0) $display("FAIL leftover: got %0d/%0d pending beats required 0/0", sq.size(), bq.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
